// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline writeback, aux result and register-file write signals
// around wb_port_arbiter. The arbiter takes the slave view; its driver takes the master view.
interface wb_port_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        stall_o;
    logic        aux_valid;
    logic [4:0]  aux_rd;
    logic [31:0] aux_wdata;
    logic        aux_ready;
    logic        aux_drop;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [15:0] force_cnt;

    modport slave (
        input  pipe_we, pipe_rd, pipe_wdata, aux_valid, aux_rd, aux_wdata,
        output stall_o, aux_ready, aux_drop, rf_we, rf_rd, rf_wdata, force_cnt
    );

    modport master (
        output pipe_we, pipe_rd, pipe_wdata, aux_valid, aux_rd, aux_wdata,
        input  stall_o, aux_ready, aux_drop, rf_we, rf_rd, rf_wdata, force_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback stream
// and a single buffered aux result. A starvation guard forces a one-cycle pipeline stall.
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus,
    output logic [1:0]        state_o
);
    // Handshake: an aux transfer occurs at a posedge where aux_valid && aux_ready;
    // aux_ready depends only on registered state, never on aux_valid.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q;
    logic [7:0]  wait_q;
    logic [4:0]  ent_rd_q;
    logic [31:0] ent_data_q;
    logic        rf_we_q;
    logic [4:0]  rf_rd_q;
    logic [31:0] rf_wdata_q;
    logic        drop_q;
    logic [15:0] force_q;

    logic pipe_busy;
    logic same_rd;

    assign pipe_busy = bus.pipe_we && (bus.pipe_rd != 5'd0);
    assign same_rd   = (bus.pipe_rd == ent_rd_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= 8'd0;
            ent_rd_q   <= 5'd0;
            ent_data_q <= 32'd0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= 32'd0;
            drop_q     <= 1'b0;
            force_q    <= 16'd0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A pipeline write in the acceptance cycle is older than the aux entry.
                    rf_we_q    <= pipe_busy;
                    rf_rd_q    <= bus.pipe_rd;
                    rf_wdata_q <= bus.pipe_wdata;
                    if (bus.aux_valid && (bus.aux_rd != 5'd0)) begin
                        ent_rd_q   <= bus.aux_rd;
                        ent_data_q <= bus.aux_wdata;
                        wait_q     <= 8'd0;
                        state_q    <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (!pipe_busy) begin
                        rf_we_q    <= 1'b1;
                        rf_rd_q    <= ent_rd_q;
                        rf_wdata_q <= ent_data_q;
                        ent_rd_q   <= 5'd0;
                        ent_data_q <= 32'd0;
                        state_q    <= S_IDLE;
                    end else begin
                        rf_we_q    <= 1'b1;
                        rf_rd_q    <= bus.pipe_rd;
                        rf_wdata_q <= bus.pipe_wdata;
                        if (same_rd) begin
                            // Pipeline value is newer; the buffered result is stale.
                            drop_q     <= 1'b1;
                            ent_rd_q   <= 5'd0;
                            ent_data_q <= 32'd0;
                            state_q    <= S_IDLE;
                        end else if (wait_q == WAIT_LAST) begin
                            state_q <= S_FORCE;
                        end else begin
                            wait_q <= wait_q + 8'd1;
                        end
                    end
                end
                S_FORCE: begin
                    // Pipeline is frozen this cycle, so its write is re-presented next cycle.
                    rf_we_q    <= 1'b1;
                    rf_rd_q    <= ent_rd_q;
                    rf_wdata_q <= ent_data_q;
                    ent_rd_q   <= 5'd0;
                    ent_data_q <= 32'd0;
                    if (force_q != 16'hFFFF) begin
                        force_q <= force_q + 16'd1;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall_o   = (state_q == S_FORCE);
    assign bus.aux_ready = (state_q == S_IDLE);
    assign bus.aux_drop  = drop_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.force_cnt = force_q;
    assign state_o       = state_q;
endmodule
